render_cmd_sched: RTL and testbench

Shares the Avalon-MM slave port of the `render` sprite engine between two draw-command requesters: requester 0 is game logic and requester 1 is the UI/score overlay. Accepted commands are round-robin arbitrated into a command FIFO. A sequencer expands each command into the renderer register-write sequence: texture to address 4, X to address 1, Y to address 2, plot trigger to address 6. The block sits between the game-control fabric and `render`, replacing hand-sequenced register pokes.

---
 rtl/render_cmd_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_render_cmd_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/render_cmd_sched.sv
// rtl/render_cmd_sched.sv - two-requester draw-command scheduler feeding the render register port
//
// Purpose: arbitrates draw commands from game logic (requester 0) and the
// UI/score overlay (requester 1) round-robin into a command FIFO, then expands
// each queued command into the renderer register-write sequence
// (texture -> addr 4, X -> addr 1, Y -> addr 2, plot trigger -> addr 6).
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   req_valid/req_ready [2]   per-requester command handshake
//   req_tex/x/y/bg      [2]   per-requester command fields
//   master_address/write/writedata/waitrequest   renderer write port
//   busy                      FIFO non-empty or sequencer active
//   fifo_count                entries currently queued
//   drop_count                saturating count of out-of-range commands discarded
module render_cmd_sched #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [1:0][6:0]          req_tex,
    input  logic [1:0][8:0]          req_x,
    input  logic [1:0][7:0]          req_y,
    input  logic [1:0]               req_bg,
    output logic [3:0]               master_address,
    output logic                     master_write,
    output logic [31:0]              master_writedata,
    input  logic                     master_waitrequest,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 25;

    // Register map of the renderer
    localparam logic [3:0] ADDR_X    = 4'd1;
    localparam logic [3:0] ADDR_Y    = 4'd2;
    localparam logic [3:0] ADDR_TEX  = 4'd4;
    localparam logic [3:0] ADDR_PLOT = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEX,
        S_X,
        S_Y,
        S_PLOT
    } state_t;

    // FIFO storage and bookkeeping
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [7:0]    drop_q, drop_d;

    // Sequencer registers
    state_t        state_q;
    logic [EW-1:0] cmd_q;
    logic          write_q;
    logic [3:0]    addr_q;
    logic [31:0]   data_q;

    logic          full;
    logic          empty;
    logic          handshake;
    logic          sel;
    logic          in_range;
    logic          push;
    logic          pop;
    logic          accept;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Arbitration: full blocks both requesters regardless of a same-cycle pop,
    // so the ready path never depends on the sequencer.
    always_comb begin
        req_ready = 2'b00;
        if (!full) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = rr_ptr_q ? 2'b10 : 2'b01;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign handshake = |(req_valid & req_ready);
    assign sel       = req_ready[1];

    // Background commands carry no usable coordinates, so they bypass the check
    assign in_range   = req_bg[sel] | ((req_x[sel] < 9'd320) && (req_y[sel] < 8'd240));
    assign push       = handshake & in_range;
    assign push_entry = {req_bg[sel], req_tex[sel], req_x[sel], req_y[sel]};

    assign pop    = (state_q == S_IDLE) && !empty;
    assign head   = mem_q[rd_ptr_q];
    assign accept = write_q & ~master_waitrequest;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (handshake) begin
            rr_ptr_d = ~rr_ptr_q;
        end
        if (handshake && !in_range && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            drop_q   <= drop_d;
        end
    end

    // Sequencer: address/data are loaded only on state entry, so they hold
    // naturally while the renderer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cmd_q   <= head;
                        state_q <= S_TEX;
                        write_q <= 1'b1;
                        addr_q  <= ADDR_TEX;
                        data_q  <= {25'd0, head[23:17]};
                    end
                end
                S_TEX: begin
                    if (accept) begin
                        if (cmd_q[24]) begin
                            state_q <= S_PLOT;
                            addr_q  <= ADDR_PLOT;
                            data_q  <= '0;
                        end else begin
                            state_q <= S_X;
                            addr_q  <= ADDR_X;
                            data_q  <= {23'd0, cmd_q[16:8]};
                        end
                    end
                end
                S_X: begin
                    if (accept) begin
                        state_q <= S_Y;
                        addr_q  <= ADDR_Y;
                        data_q  <= {24'd0, cmd_q[7:0]};
                    end
                end
                S_Y: begin
                    if (accept) begin
                        state_q <= S_PLOT;
                        addr_q  <= ADDR_PLOT;
                        data_q  <= '0;
                    end
                end
                S_PLOT: begin
                    if (accept) begin
                        state_q <= S_IDLE;
                        write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign master_write     = write_q;
    assign master_address   = addr_q;
    assign master_writedata = data_q;
    assign busy             = !empty || (state_q != S_IDLE);
    assign fifo_count       = count_q;
    assign drop_count       = drop_q;

endmodule

// File: tb/tb_render_cmd_sched.sv
// tb/tb_render_cmd_sched.sv - directed self-checking bench for render_cmd_sched
module tb_render_cmd_sched;

    logic             clk;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][6:0]  req_tex;
    logic [1:0][8:0]  req_x;
    logic [1:0][7:0]  req_y;
    logic [1:0]       req_bg;
    logic [3:0]       master_address;
    logic             master_write;
    logic [31:0]      master_writedata;
    logic             master_waitrequest;
    logic             busy;
    logic [3:0]       fifo_count;
    logic [7:0]       drop_count;

    int checks = 0;
    int failures = 0;

    render_cmd_sched #(.DEPTH(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_tex            (req_tex),
        .req_x              (req_x),
        .req_y              (req_y),
        .req_bg             (req_bg),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest),
        .busy               (busy),
        .fifo_count         (fifo_count),
        .drop_count         (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        master_waitrequest = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (master_write !== 1'b0) begin failures++; $display("FAIL rst_write got=%0h exp=0", master_write); end
        checks++; if (master_address !== 4'd0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", master_address); end
        checks++; if (master_writedata !== 32'd0) begin failures++; $display("FAIL rst_data got=%0h exp=0", master_writedata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        checks++; if (fifo_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL rst_drop got=%0d exp=0", drop_count); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_ready_none got=%b exp=00", req_ready); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_rr_start got=%b exp=01", req_ready); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_single_sprite();
        logic [3:0]  ea [4] = '{4'd4, 4'd1, 4'd2, 4'd6};
        logic [31:0] ed [4] = '{32'h06, 32'd159, 32'd119, 32'd0};
        req_tex[0] = 7'h06; req_x[0] = 9'd159; req_y[0] = 8'd119; req_bg[0] = 1'b0;
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL ss_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++; if (fifo_count !== 4'd1) begin failures++; $display("FAIL ss_count got=%0d exp=1", fifo_count); end
        checks++; if (master_write !== 1'b0) begin failures++; $display("FAIL ss_idle_write got=%0h exp=0", master_write); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (master_write !== 1'b1 || master_address !== ea[i] || master_writedata !== ed[i]) begin
                failures++;
                $display("FAIL ss_write%0d got=(%0b,%0d,%0h) exp=(1,%0d,%0h)", i, master_write, master_address, master_writedata, ea[i], ed[i]);
            end
        end
        tick();
        checks++; if (master_write !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ss_done got=(w%0b,b%0b) exp=(0,0)", master_write, busy); end
    endtask

    task automatic test_background();
        req_tex[1] = 7'h6A; req_x[1] = 9'd400; req_y[1] = 8'd0; req_bg[1] = 1'b1;
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bg_ready got=%b exp=10", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++; if (fifo_count !== 4'd1) begin failures++; $display("FAIL bg_count got=%0d exp=1", fifo_count); end
        tick();
        checks++; if (master_write !== 1'b1 || master_address !== 4'd4 || master_writedata !== 32'h6A) begin failures++; $display("FAIL bg_tex got=(%0b,%0d,%0h) exp=(1,4,6a)", master_write, master_address, master_writedata); end
        tick();
        checks++; if (master_write !== 1'b1 || master_address !== 4'd6 || master_writedata !== 32'd0) begin failures++; $display("FAIL bg_plot got=(%0b,%0d,%0h) exp=(1,6,0)", master_write, master_address, master_writedata); end
        tick();
        checks++; if (master_write !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bg_done got=(w%0b,b%0b) exp=(0,0)", master_write, busy); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL bg_drop got=%0d exp=0", drop_count); end
    endtask

    task automatic test_waitrequest();
        req_tex[0] = 7'h11; req_x[0] = 9'd5; req_y[0] = 8'd7; req_bg[0] = 1'b0;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        checks++; if (master_address !== 4'd4 || master_writedata !== 32'h11) begin failures++; $display("FAIL wr_tex got=(%0d,%0h) exp=(4,11)", master_address, master_writedata); end
        tick();
        checks++; if (master_write !== 1'b1 || master_address !== 4'd1 || master_writedata !== 32'd5) begin failures++; $display("FAIL wr_x0 got=(%0b,%0d,%0h) exp=(1,1,5)", master_write, master_address, master_writedata); end
        master_waitrequest = 1'b1;
        for (int j = 1; j < 4; j++) begin
            tick();
            checks++;
            if (master_write !== 1'b1 || master_address !== 4'd1 || master_writedata !== 32'd5) begin
                failures++;
                $display("FAIL wr_x%0d got=(%0b,%0d,%0h) exp=(1,1,5)", j, master_write, master_address, master_writedata);
            end
        end
        master_waitrequest = 1'b0;
        tick();
        checks++; if (master_write !== 1'b1 || master_address !== 4'd2 || master_writedata !== 32'd7) begin failures++; $display("FAIL wr_y got=(%0b,%0d,%0h) exp=(1,2,7)", master_write, master_address, master_writedata); end
        tick();
        checks++; if (master_address !== 4'd6) begin failures++; $display("FAIL wr_plot got=%0d exp=6", master_address); end
        tick();
        checks++; if (master_write !== 1'b0) begin failures++; $display("FAIL wr_done got=%0b exp=0", master_write); end
    endtask

    task automatic test_out_of_range();
        req_tex[0] = 7'h01; req_x[0] = 9'd320; req_y[0] = 8'd10; req_bg[0] = 1'b0;
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL oor_ready got=%b exp=01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++; if (drop_count !== 8'd1 || fifo_count !== 4'd0) begin failures++; $display("FAIL oor_first got=(d%0d,c%0d) exp=(1,0)", drop_count, fifo_count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (master_write !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL oor_nowrite%0d got=(w%0b,b%0b) exp=(0,0)", i, master_write, busy); end
        end
        req_x[0] = 9'd0; req_y[0] = 8'd240;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        checks++; if (drop_count !== 8'd2 || fifo_count !== 4'd0) begin failures++; $display("FAIL oor_y240 got=(d%0d,c%0d) exp=(2,0)", drop_count, fifo_count); end
        req_x[0] = 9'd319; req_y[0] = 8'd239;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        checks++; if (drop_count !== 8'd2 || fifo_count !== 4'd1) begin failures++; $display("FAIL oor_edge_legal got=(d%0d,c%0d) exp=(2,1)", drop_count, fifo_count); end
        repeat (6) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL oor_drain got=%0b exp=0", busy); end
        req_x[0] = 9'd320; req_y[0] = 8'd10;
        req_valid = 2'b01;
        repeat (298) tick();
        req_valid = 2'b00;
        checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL oor_saturate got=%0d exp=255", drop_count); end
        checks++; if (busy !== 1'b0 || fifo_count !== 4'd0) begin failures++; $display("FAIL oor_idle got=(b%0b,c%0d) exp=(0,0)", busy, fifo_count); end
    endtask

    task automatic test_contention();
        logic [6:0] exp_tex [9] = '{7'h10, 7'h20, 7'h11, 7'h21, 7'h12, 7'h22, 7'h13, 7'h23, 7'h14};
        int n0 = 0;
        int n1 = 0;
        int idx = 0;
        logic [1:0] er;
        logic [3:0] ec;
        do_reset();
        master_waitrequest = 1'b1;
        req_x = '{9'd10, 9'd10}; req_y = '{8'd20, 8'd20}; req_bg = 2'b00;
        req_valid = 2'b11;
        for (int k = 0; k < 9; k++) begin
            req_tex[0] = 7'h10 + 7'(n0);
            req_tex[1] = 7'h20 + 7'(n1);
            er = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (req_ready !== er) begin failures++; $display("FAIL ct_ready%0d got=%b exp=%b", k, req_ready, er); end
            if (er[0]) n0++; else n1++;
            tick();
            ec = (k == 0) ? 4'd1 : 4'(k);
            checks++; if (fifo_count !== ec) begin failures++; $display("FAIL ct_count%0d got=%0d exp=%0d", k, fifo_count, ec); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (req_ready !== 2'b00 || fifo_count !== 4'd8) begin failures++; $display("FAIL ct_full%0d got=(r%b,c%0d) exp=(00,8)", i, req_ready, fifo_count); end
            tick();
        end
        checks++; if (master_write !== 1'b1 || master_address !== 4'd4 || master_writedata !== 32'h10) begin failures++; $display("FAIL ct_stalled got=(%0b,%0d,%0h) exp=(1,4,10)", master_write, master_address, master_writedata); end
        req_valid = 2'b00;
        master_waitrequest = 1'b0;
        for (int cyc = 0; cyc < 100 && idx < 9; cyc++) begin
            if (master_write === 1'b1 && master_address === 4'd4) begin
                checks++;
                if (master_writedata !== {25'd0, exp_tex[idx]}) begin failures++; $display("FAIL ct_order%0d got=%0h exp=%0h", idx, master_writedata, exp_tex[idx]); end
                idx++;
            end
            tick();
        end
        checks++; if (idx !== 9) begin failures++; $display("FAIL ct_timeout got=%0d exp=9", idx); end
        repeat (6) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ct_drain got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_tex[0] = 7'h30; req_x[0] = 9'd1; req_y[0] = 8'd2; req_bg[0] = 1'b0;
        req_valid = 2'b01;
        repeat (4) tick();
        req_valid = 2'b00;
        master_waitrequest = 1'b1;
        checks++; if (master_address !== 4'd2 || fifo_count !== 4'd3) begin failures++; $display("FAIL rm_setup got=(a%0d,c%0d) exp=(2,3)", master_address, fifo_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        master_waitrequest = 1'b0;
        checks++; if (master_write !== 1'b0 || fifo_count !== 4'd0 || busy !== 1'b0 || master_address !== 4'd0) begin
            failures++;
            $display("FAIL rm_cleared got=(w%0b,c%0d,b%0b,a%0d) exp=(0,0,0,0)", master_write, fifo_count, busy, master_address);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (master_write !== 1'b0) begin failures++; $display("FAIL rm_nowrite%0d got=%0b exp=0", i, master_write); end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        req_tex = '0;
        req_x = '0;
        req_y = '0;
        req_bg = '0;
        master_waitrequest = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_sprite();
        test_background();
        test_waitrequest();
        test_out_of_range();
        test_contention();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
